// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the UART transmit buffer and the tops that instantiate it.
`include "uart_common_defs.sv"

package uart_tx_fifo_pkg;
    localparam int UART_TX_FIFO_DEPTH = 16;
    localparam int DATA_W             = `DATA_WIDTH;
endpackage

// File: rtl/fifo_ram.sv
// Storage array for the TX FIFO: synchronous write, asynchronous read.
// Zero-latency read; no flow control here, the caller owns the pointers.
`include "uart_common_defs.sv"

module fifo_ram
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = UART_TX_FIFO_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input  logic                     i_clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_common_defs.sv
// Shared definitions for the UART datapath; data width of every byte lane.
`ifndef UART_COMMON_DEFS_SV
`define UART_COMMON_DEFS_SV
`define DATA_WIDTH 8
`endif

// File: rtl/uart_tx_fifo.sv
// First-word fall-through TX FIFO: push visible one cycle later, head read combinationally.
// Pushes while full are dropped (sticky overflow) unless a pop frees the slot that same edge.
`include "uart_common_defs.sv"

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     wr_en,
    input  logic [`DATA_WIDTH-1:0]   wr_data,
    output logic                     fifo_full,
    output logic                     almost_full,
    input  logic                     fifo_read_en,
    output logic [`DATA_WIDTH-1:0]   fifo_data,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AFULL_CNT = AFULL_LEVEL[AW:0];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] rd_ptr_nxt;
    logic        push_acc;
    logic        pop_acc;
    logic        push_drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop while full frees the slot being written, so the push goes through.
    assign pop_acc   = fifo_read_en && !fifo_empty;
    assign push_acc  = wr_en && (!fifo_full || fifo_read_en);
    assign push_drop = wr_en && fifo_full && !fifo_read_en;

    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push_acc};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop_acc};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= wr_ptr_nxt - rd_ptr_nxt;
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign almost_full = (count >= AFULL_CNT);

    fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (`DATA_WIDTH)
    ) u_ram (
        .i_clk (i_clk),
        .we    (push_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (fifo_data)
    );
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DEPTH=4, AFULL_LEVEL=3.
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              fifo_full;
    logic              almost_full;
    logic              rd_en;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic [2:0]        count;
    logic              overflow;
    logic              ovf_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH       (4),
        .AFULL_LEVEL (3)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .fifo_read_en (rd_en),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .count        (count),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({fifo_empty, fifo_full, almost_full, overflow} !== 4'b1000) begin
            bad++; $display("FAIL reset_flags: got e/f/af/ovf=%b want 1000", {fifo_empty, fifo_full, almost_full, overflow});
        end
        total++;
        if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_push;
        wr_en = 1'b1; wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        total++;
        if (fifo_empty !== 1'b0) begin bad++; $display("FAIL push_empty: got %b want 0", fifo_empty); end
        total++;
        if (fifo_data !== 8'h41) begin bad++; $display("FAIL push_data: got %h want 41", fifo_data); end
        total++;
        if (count !== 3'd1) begin bad++; $display("FAIL push_count: got %0d want 1", count); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++;
        if (fifo_empty !== 1'b1 || count !== 3'd0) begin
            bad++; $display("FAIL pop_single: got empty=%b count=%0d want 1/0", fifo_empty, count);
        end
    endtask

    task automatic test_fill_overflow;
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            total++;
            if (count !== 3'(i) || almost_full !== (i >= 3) || fifo_full !== (i == 4)) begin
                bad++; $display("FAIL fill_%0d: got count=%0d af=%b full=%b want %0d/%b/%b",
                                i, count, almost_full, fifo_full, i, (i >= 3), (i == 4));
            end
        end
        wr_data = 8'h05;
        tick();
        wr_en = 1'b0;
        total++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            bad++; $display("FAIL drop_push: got ovf=%b count=%0d want 1/4", overflow, count);
        end
        rd_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (fifo_data !== 8'(i)) begin bad++; $display("FAIL drain_%0d: got %h want %h", i, fifo_data, 8'(i)); end
            tick();
        end
        rd_en = 1'b0;
        total++;
        if (fifo_empty !== 1'b1 || overflow !== 1'b1) begin
            bad++; $display("FAIL drained: got empty=%b ovf=%b want 1/1", fifo_empty, overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    endtask

    task automatic test_full_simul;
        logic [DATA_W-1:0] exp_q [4];
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h55};
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h11 + i);
            tick();
        end
        wr_data = 8'h55; rd_en = 1'b1;
        total++;
        if (fifo_full !== 1'b1 || fifo_data !== 8'h11) begin
            bad++; $display("FAIL full_head: got full=%b data=%h want 1/11", fifo_full, fifo_data);
        end
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        total++;
        if (count !== 3'd4 || fifo_full !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL full_simul: got count=%0d full=%b ovf=%b want 4/1/0", count, fifo_full, overflow);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (fifo_data !== exp_q[i]) begin bad++; $display("FAIL full_order_%0d: got %h want %h", i, fifo_data, exp_q[i]); end
            tick();
        end
        rd_en = 1'b0;
        total++;
        if (fifo_empty !== 1'b1) begin bad++; $display("FAIL full_drained: got empty=%b want 1", fifo_empty); end
    endtask

    task automatic test_empty_simul;
        wr_en = 1'b1; wr_data = 8'h7E; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        total++;
        if (count !== 3'd1 || fifo_empty !== 1'b0 || fifo_data !== 8'h7E) begin
            bad++; $display("FAIL empty_simul: got count=%0d empty=%b data=%h want 1/0/7e", count, fifo_empty, fifo_data);
        end
        rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0;
        total++;
        if (count !== 3'd0 || fifo_empty !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL pop_empty: got count=%0d empty=%b ovf=%b want 0/1/0", count, fifo_empty, overflow);
        end
    endtask

    task automatic test_back_to_back;
        wr_en = 1'b1; wr_data = 8'h00;
        tick();
        for (int i = 1; i <= 9; i++) begin
            wr_data = 8'(i); rd_en = 1'b1;
            total++;
            if (fifo_empty !== 1'b0 || fifo_data !== 8'(i - 1)) begin
                bad++; $display("FAIL wrap_data_%0d: got empty=%b data=%h want 0/%h", i, fifo_empty, fifo_data, 8'(i - 1));
            end
            tick();
            total++;
            if (count !== 3'd1 || fifo_full !== 1'b0 || almost_full !== 1'b0) begin
                bad++; $display("FAIL wrap_flags_%0d: got count=%0d full=%b af=%b want 1/0/0", i, count, fifo_full, almost_full);
            end
        end
        wr_en = 1'b0;
        total++;
        if (fifo_data !== 8'h09) begin bad++; $display("FAIL wrap_last: got %h want 09", fifo_data); end
        tick();
        rd_en = 1'b0;
        total++;
        if (fifo_empty !== 1'b1 || count !== 3'd0) begin
            bad++; $display("FAIL wrap_end: got empty=%b count=%0d want 1/0", fifo_empty, count);
        end
    endtask

    task automatic test_reset_mid;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(8'hA0 + i);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++;
        if (count !== 3'd3 || overflow !== 1'b1) begin
            bad++; $display("FAIL pre_reset: got count=%0d ovf=%b want 3/1", count, overflow);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || {fifo_empty, fifo_full, almost_full, overflow} !== 4'b1000) begin
            bad++; $display("FAIL async_reset: got count=%0d e/f/af/ovf=%b want 0/1000",
                            count, {fifo_empty, fifo_full, almost_full, overflow});
        end
        #2;
        rst_n = 1'b1;
        tick();
        total++;
        if (fifo_empty !== 1'b1) begin bad++; $display("FAIL post_reset: got empty=%b want 1", fifo_empty); end
    endtask

    task automatic test_ovf_priority;
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0;
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL drop_over_clr: got %b want 1", overflow); end
        tick();
        ovf_clr = 1'b0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL clr_after: got %b want 0", overflow); end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (fifo_data !== 8'(8'hC0 + i)) begin bad++; $display("FAIL ovf_order_%0d: got %h want %h", i, fifo_data, 8'(8'hC0 + i)); end
            tick();
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_full_simul();
        test_empty_simul();
        test_back_to_back();
        test_reset_mid();
        test_ovf_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, minimum 2.
REQ-002 SHALL have parameter AFULL_LEVEL, default DEPTH-2, fill level at which almost_full asserts.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wr_en  input  1  producer push request.
REQ-006 SHALL have port wr_data  input  `DATA_WIDTH  push data.
REQ-007 SHALL have port fifo_full  output  1  no free entry.
REQ-008 SHALL have port almost_full  output  1  count >= AFULL_LEVEL.
REQ-009 SHALL have port fifo_read_en  input  1  consumer pop, driven by the UART writer.
REQ-010 SHALL have port fifo_data  output  `DATA_WIDTH  head entry, first-word fall-through.
REQ-011 SHALL have port fifo_empty  output  1  no valid entry.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current fill level.
REQ-013 SHALL have port overflow  output  1  sticky; a push was dropped.
REQ-014 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-015 SHALL keep read and write pointers $clog2(DEPTH)+1 bits wide, MSB as wrap bit, incrementing modulo 2*DEPTH.
REQ-016 SHALL assert fifo_empty when the pointers are equal, and fifo_full when the low bits are equal and the MSBs differ; both decoded from registered pointers.
REQ-017 SHALL drive fifo_data combinationally from mem[rd_ptr low bits]: valid in the same cycle fifo_empty is low, and held stable until the cycle after a pop.
REQ-018 SHALL accept a push when wr_en=1 and either fifo_full=0 or fifo_read_en=1; data is written at wr_ptr and wr_ptr increments on that edge.
REQ-019 SHALL accept a pop when fifo_read_en=1 and fifo_empty=0; rd_ptr increments on that edge.
REQ-020 SHALL ignore fifo_read_en while empty: no pointer change, no error flag.
REQ-021 SHALL, on a simultaneous push and pop, leave count unchanged; when full, the pop frees the slot and the push is accepted.
REQ-022 SHALL, on a simultaneous push and pop while empty, accept only the push; fifo_empty deasserts on the next cycle.
REQ-023 SHALL drop a push when full with no pop, and set overflow on that edge.
REQ-024 SHALL clear overflow on ovf_clr=1; a simultaneous new drop takes priority and keeps overflow set.
REQ-025 SHALL update count as wr_ptr minus rd_ptr, registered, one cycle after the accepted operation; almost_full is derived from the registered count.
REQ-026 SHALL have a latency of one cycle from push to fifo_empty=0, with fifo_data valid in that same cycle.

Reset
REQ-027 SHALL, while i_rst_n=0, force: pointers=0, count=0, fifo_empty=1, fifo_full=0, almost_full=0, overflow=0.
REQ-028 SHALL leave storage contents unreset; fifo_data is don't-care while fifo_empty=1.
REQ-029 SHALL discard all buffered data on reset asserted mid-operation, with no partial pop or push completing.

Structure
REQ-030 SHALL take `DATA_WIDTH from the shared common header; the shared package holds a FIFO depth constant UART_TX_FIFO_DEPTH=16 used by instantiating tops.
REQ-031 SHALL place storage in one sub-module, fifo_ram: DEPTH x DATA_WIDTH, one synchronous write port and one asynchronous read port; pointer and flag logic stays in uart_tx_fifo.
REQ-032 SHALL connect directly to the UART writer's fifo_empty, fifo_data and fifo_read_en with no glue logic.

Verification (DEPTH=4, AFULL_LEVEL=3)
REQ-033 SHALL cover: reset, then push 0x41 -> next cycle fifo_empty=0, fifo_data=0x41, count=1.
REQ-034 SHALL cover: push 0x01..0x04 -> fifo_full=1, almost_full=1 from count=3; a fifth push 0x05 -> dropped, overflow=1, and pops return 0x01..0x04.
REQ-035 SHALL cover: full, then simultaneous push 0x55 and pop -> pop returns head, count stays 4, 0x55 emerges last.
REQ-036 SHALL cover: empty, simultaneous push 0x7E and pop -> count=1, fifo_data=0x7E; pop while empty -> count stays 0.
REQ-037 SHALL cover: 10 push/pop cycles of 0x00..0x09 across pointer wrap -> output order preserved, flags correct at each step.
REQ-038 SHALL cover: i_rst_n low mid-stream with count=3 -> asynchronously count=0 and fifo_empty=1; overflow cleared; ovf_clr clears a set flag.
